line_uart_tx: RTL

Consumer end of the fizzbuzz line interface. Latches the packed 8×4-bit character line from the fizzbuzz generator and translates each code to ASCII. Transmits the text as 8N1 UART with CR LF after each line, then pulses `next` to advance the generator. Stops after a fixed number of lines; sits between the fizzbuzz core and the board TX pin.

---
 rtl/line_uart_tx.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/line_uart_tx.sv
// Fizzbuzz line consumer. Each latched 8x4-bit code line is sent as ASCII over 8N1 UART,
// followed by CR LF, and a one-cycle `next` pulse then requests the following line.
module line_uart_tx #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int LINES        = 100,
    parameter int SETTLE       = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] line,
    input  logic        isnum,
    output logic        next,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int LINE_W = $clog2(LINES + 1);
    localparam int SET_W  = $clog2(SETTLE + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [LINE_W-1:0] LINE_MAX  = LINE_W'(LINES);
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_FETCH, S_START, S_DATA, S_STOP, S_ADV, S_DONE
    } state_t;

    typedef enum logic [1:0] {P_CHAR, P_CR, P_LF} phase_t;

    state_t             r_state, w_state_nxt;
    phase_t             r_phase, w_phase_nxt;
    logic [BAUD_W-1:0]  r_baud,  w_baud_nxt;
    logic [2:0]         r_bit,   w_bit_nxt;
    logic [2:0]         r_idx,   w_idx_nxt;
    logic [LINE_W-1:0]  r_lines, w_lines_nxt;
    logic [SET_W-1:0]   r_settle, w_settle_nxt;
    logic               r_tx,   w_tx_nxt;
    logic               r_next, w_next_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;

    logic [31:0]        r_line;
    logic               r_isnum;

    logic [2:0]         w_idx_inc;
    logic [2:0]         w_bit_inc;
    logic [3:0]         w_nib;
    logic [3:0]         w_nib_next;
    logic [7:0]         w_byte;
    logic [LINE_W-1:0]  w_lines_inc;
    logic               w_baud_end;

    // Codes illegal for the latched line type become '?' so character positions are preserved.
    function automatic logic [7:0] code_to_ascii(input logic [3:0] code, input logic num);
        logic [7:0] ch;
        ch = 8'h3F;
        if (code <= 4'd9) begin
            if (num)
                ch = 8'h30 + {4'h0, code};
        end else if (!num) begin
            case (code)
                4'd10:   ch = 8'h42;
                4'd11:   ch = 8'h46;
                4'd12:   ch = 8'h69;
                4'd13:   ch = 8'h75;
                4'd14:   ch = 8'h7A;
                default: ch = 8'h3F;
            endcase
        end
        return ch;
    endfunction

    assign w_idx_inc   = r_idx + 3'd1;
    assign w_bit_inc   = r_bit + 3'd1;
    assign w_nib       = r_line[{r_idx, 2'b00} +: 4];
    assign w_nib_next  = r_line[{w_idx_inc, 2'b00} +: 4];
    assign w_lines_inc = r_lines + 1'b1;
    assign w_baud_end  = (r_baud == BAUD_LAST);

    always_comb begin
        w_byte = 8'h0A;
        case (r_phase)
            P_CHAR:  w_byte = code_to_ascii(w_nib, r_isnum);
            P_CR:    w_byte = 8'h0D;
            default: w_byte = 8'h0A;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;
        w_baud_nxt   = r_baud;
        w_bit_nxt    = r_bit;
        w_idx_nxt    = r_idx;
        w_lines_nxt  = r_lines;
        w_settle_nxt = r_settle;
        w_tx_nxt     = r_tx;
        w_next_nxt   = 1'b0;
        w_busy_nxt   = r_busy;
        w_done_nxt   = r_done;

        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (start) begin
                    w_state_nxt = S_FETCH;
                    w_busy_nxt  = 1'b1;
                end
            end

            S_SETTLE: begin
                if (r_settle == SET_LAST) begin
                    w_settle_nxt = '0;
                    w_state_nxt  = S_FETCH;
                end else begin
                    w_settle_nxt = r_settle + 1'b1;
                end
            end

            // An empty line (terminator in nibble 0) goes straight to CR.
            S_FETCH: begin
                w_idx_nxt   = '0;
                w_phase_nxt = (line[3:0] == 4'hF) ? P_CR : P_CHAR;
                w_baud_nxt  = '0;
                w_tx_nxt    = 1'b0;
                w_state_nxt = S_START;
            end

            S_START: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = w_byte[0];
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end

            S_DATA: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = w_bit_inc;
                        w_tx_nxt  = w_byte[w_bit_inc];
                    end
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end

            S_STOP: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    if (r_phase == P_LF) begin
                        w_lines_nxt = w_lines_inc;
                        if (w_lines_inc == LINE_MAX) begin
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                            w_state_nxt = S_DONE;
                        end else begin
                            w_next_nxt   = 1'b1;
                            w_settle_nxt = '0;
                            w_state_nxt  = S_SETTLE;
                        end
                    end else begin
                        w_state_nxt = S_ADV;
                    end
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end

            S_ADV: begin
                if (r_phase == P_CHAR) begin
                    if (r_idx == 3'd7 || w_nib_next == 4'hF)
                        w_phase_nxt = P_CR;
                    else
                        w_idx_nxt = w_idx_inc;
                end else begin
                    w_phase_nxt = P_LF;
                end
                w_tx_nxt    = 1'b0;
                w_state_nxt = S_START;
            end

            S_DONE: begin
                w_tx_nxt = 1'b1;
            end

            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_phase  <= P_CHAR;
            r_baud   <= '0;
            r_bit    <= '0;
            r_idx    <= '0;
            r_lines  <= '0;
            r_settle <= '0;
            r_tx     <= 1'b1;
            r_next   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_phase  <= w_phase_nxt;
            r_baud   <= w_baud_nxt;
            r_bit    <= w_bit_nxt;
            r_idx    <= w_idx_nxt;
            r_lines  <= w_lines_nxt;
            r_settle <= w_settle_nxt;
            r_tx     <= w_tx_nxt;
            r_next   <= w_next_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Line contents are frozen at FETCH; the producer may change them freely afterwards.
    always_ff @(posedge clk) begin
        if (r_state == S_FETCH) begin
            r_line  <= line;
            r_isnum <= isnum;
        end
    end

    assign tx   = r_tx;
    assign next = r_next;
    assign busy = r_busy;
    assign done = r_done;

endmodule
